fetch_aligner: RTL and testbench
================================

Name: fetch_aligner

Overview:
- Fetch-side controller that sequences 32-bit word reads from instruction memory and splits the returned words into a halfword stream.
- Presents one instruction at a time (16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary) with its PC and a compressed flag.
- Sits between instruction memory and decode. Downstream feeds instruction[15:0] to the decompressor and uses the compressed flag to select between the decompressor result and the raw 32-bit word.
- Also owns PC sequencing (+2/+4) and redirect/flush handling.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored, bit 1 may be set.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, synchronous active-low reset.
- memReq, output, 1, one-cycle pulse requesting the word at memAddr.
- memAddr, output, 32, word address, bits [1:0] always 00; valid while memReq=1.
- memValid, input, 1, response strobe for the single outstanding request; arrives at least 1 cycle after memReq.
- memData, input, 32, response word; [15:0] = halfword at memAddr, [31:16] = halfword at memAddr+2.
- redirect, input, 1, flush and restart fetch at redirectTarget.
- redirectTarget, input, 32, new PC; bit 0 ignored.
- instValid, output, 1, instruction/instPC/compressed are valid.
- instReady, input, 1, downstream accepts; transfer occurs when instValid & instReady.
- instruction, output, 32, {16'b0, halfword} when compressed, else the full 32-bit instruction.
- compressed, output, 1, 1 when head halfword[1:0] != 2'b11.
- instPC, output, 32, PC of the presented instruction.

Behaviour:
- **Buffer:** 4-entry halfword FIFO (bufCnt 0..4) with head PC register headPC. Fetch pointer fetchPC is word-aligned. skipHalf flag marks a first fetch after a halfword-aligned start.
- **Reset** (rst=0 at clock edge):
  - bufCnt=0, FSM=S_REQ, fetchPC={RESET_PC[31:2],2'b00}, skipHalf=RESET_PC[1], headPC={RESET_PC[31:1],1'b0}.
  - Outputs: memReq=0, memAddr=fetchPC, instValid=0, instruction=0, compressed=0, instPC=headPC.
  - Reset mid-operation discards all state, including any outstanding request. The memory side is reset on the same rst.
- **Output decode:** combinational from buffer registers. No added latency.
  - instValid = (bufCnt>=1 & head[1:0]!=11) | (bufCnt>=2 & head[1:0]==11).
  - A 32-bit instruction = {entry1, entry0}. When instValid=0, instruction and compressed hold 0.
- **Accept:** on transfer, pop 1 entry (compressed) or 2 entries (32-bit), and headPC += 2 or 4. Outputs are stable while instValid=1 and instReady=0.
- **FSM:**
  - *S_REQ* (nothing outstanding):
    - If bufCnt_after_pop <= 2 and no redirect: assert memReq with memAddr=fetchPC, then go to S_WAIT.
    - Otherwise stay.
  - *S_WAIT:*
    - On memValid: push memData[15:0] (unless skipHalf) then memData[31:16]. Clear skipHalf, fetchPC += 4, go to S_REQ.
    - Push and pop in the same cycle are allowed; the net count never exceeds 4, guaranteed by the issue rule.
  - *S_DROP* (stale request outstanding): on memValid, discard data and go to S_REQ.
  - memValid in S_REQ is ignored.
- **Redirect** (highest priority, any state):
  - Next cycle: bufCnt=0, headPC={redirectTarget[31:1],0}, fetchPC={redirectTarget[31:2],00}, skipHalf=redirectTarget[1].
  - FSM goes to S_DROP if a request is outstanding and memValid=0 this cycle; otherwise to S_REQ.
  - memValid coincident with redirect: data discarded, FSM goes to S_REQ.
  - memReq is never asserted in the redirect cycle. The first post-redirect request is issued the cycle after redirect, or the cycle after the stale response.
  - A transfer coincident with redirect is counted as accepted by downstream; buffer state is still flushed.
- **Latency:** memReq in cycle 0 and memValid in cycle L give instValid in cycle L+1. The first memReq is in the first cycle with rst=1.
- **Address wrap:** fetchPC and headPC wrap modulo 2^32 with no special handling.

Test Plan:
1. Reset RESET_PC=0, 1-cycle memory, mem[0]=32'h00A00093, mem[4]=32'h4505_4501, instReady=1.
   - Expect: instruction=32'h00A00093, compressed=0, instPC=0.
   - Then 32'h00004501 at PC 4 and 32'h00004505 at PC 6, both with compressed=1.
2. Straddle: mem[8]=32'h0093_4501, mem[12]=32'h1234_00A0.
   - Expect: PC 8 gives 32'h00004501 (c).
   - PC 10 gives 32'h00A00093 (not compressed), presented only after the second word returns.
   - PC 14 gives 32'h00001234 (c).
3. Redirect to 32'h0000_0102 while a request to 0x10 is outstanding (3-cycle memory).
   - Expect: the 0x10 response is discarded.
   - Next memAddr=0x100, only memData[31:16] is used, instPC=0x102.
4. Backpressure: all-compressed memory, instReady=0 for 10 cycles.
   - Expect: bufCnt saturates at 4 and no memReq is issued while bufCnt>2.
   - Outputs hold; on release, consecutive PCs with no missing or duplicated halfword.
5. Redirect coincident with memValid, target 0x40.
   - Expect: data dropped, instValid=0 the next cycle, memReq with memAddr=0x40 the cycle after redirect.
6. rst=0 for one cycle during S_WAIT.
   - Expect: all outputs at reset values, memReq to RESET_PC in the first cycle after rst returns to 1, and a late memValid from the old request is ignored.

Source files
------------

// File: rtl/fetch_aligner.sv
// Fetch aligner: issues word reads, splits returned words into a halfword FIFO and
// presents one 16-bit or 32-bit instruction at a time with its PC.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memValid,
    input  logic [31:0] memData,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] instruction,
    output logic        compressed,
    output logic [31:0] instPC
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t      r_state;
    logic [15:0] r_buf [0:3];
    logic [2:0]  r_bufCnt;
    logic [31:0] r_headPC;
    logic [31:0] r_fetchPC;
    logic        r_skipHalf;

    logic        w_headIsComp;
    logic        w_instValid;
    logic        w_accept;
    logic [2:0]  w_popN;
    logic [2:0]  w_cntAfterPop;
    logic        w_issue;
    logic        w_push;
    logic [15:0] w_nextBuf [0:3];
    logic [2:0]  w_nextCnt;
    logic        w_unusedTargetBit;

    assign w_unusedTargetBit = redirectTarget[0];

    assign w_headIsComp  = (r_buf[0][1:0] != 2'b11);
    assign w_instValid   = ((r_bufCnt >= 3'd1) && w_headIsComp) ||
                           ((r_bufCnt >= 3'd2) && !w_headIsComp);
    assign w_accept      = w_instValid && instReady;
    assign w_popN        = !w_accept ? 3'd0 : (w_headIsComp ? 3'd1 : 3'd2);
    assign w_cntAfterPop = r_bufCnt - w_popN;
    // Issuing only when at most two entries remain keeps a full-word push within capacity.
    assign w_issue       = rst && (r_state == S_REQ) && !redirect && (w_cntAfterPop <= 3'd2);
    assign w_push        = (r_state == S_WAIT) && memValid;

    assign memReq      = w_issue;
    assign memAddr     = r_fetchPC;
    assign instValid   = w_instValid;
    assign compressed  = w_instValid && w_headIsComp;
    assign instPC      = r_headPC;
    assign instruction = !w_instValid ? 32'h0 :
                         (w_headIsComp ? {16'h0, r_buf[0]} : {r_buf[1], r_buf[0]});

    always_comb begin
        w_nextBuf[0] = r_buf[0];
        w_nextBuf[1] = r_buf[1];
        w_nextBuf[2] = r_buf[2];
        w_nextBuf[3] = r_buf[3];
        if (w_popN == 3'd2) begin
            w_nextBuf[0] = r_buf[2];
            w_nextBuf[1] = r_buf[3];
            w_nextBuf[2] = 16'h0;
            w_nextBuf[3] = 16'h0;
        end else if (w_popN == 3'd1) begin
            w_nextBuf[0] = r_buf[1];
            w_nextBuf[1] = r_buf[2];
            w_nextBuf[2] = r_buf[3];
            w_nextBuf[3] = 16'h0;
        end
        w_nextCnt = w_cntAfterPop;
        // Arriving halves land behind whatever survives this cycle's pop.
        if (w_push) begin
            if (!r_skipHalf) begin
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) == w_nextCnt) w_nextBuf[i] = memData[15:0];
                end
                w_nextCnt = w_nextCnt + 3'd1;
            end
            for (int i = 0; i < 4; i++) begin
                if (3'(i) == w_nextCnt) w_nextBuf[i] = memData[31:16];
            end
            w_nextCnt = w_nextCnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_REQ;
            r_bufCnt   <= 3'd0;
            r_fetchPC  <= {RESET_PC[31:2], 2'b00};
            r_skipHalf <= RESET_PC[1];
            r_headPC   <= {RESET_PC[31:1], 1'b0};
            for (int i = 0; i < 4; i++) r_buf[i] <= 16'h0;
        end else if (redirect) begin
            r_bufCnt   <= 3'd0;
            r_headPC   <= {redirectTarget[31:1], 1'b0};
            r_fetchPC  <= {redirectTarget[31:2], 2'b00};
            r_skipHalf <= redirectTarget[1];
            // A still-pending response belongs to the old stream and must be swallowed.
            r_state    <= ((r_state == S_WAIT || r_state == S_DROP) && !memValid) ? S_DROP : S_REQ;
        end else begin
            r_buf    <= w_nextBuf;
            r_bufCnt <= w_nextCnt;
            if (w_accept) r_headPC <= r_headPC + (w_headIsComp ? 32'd2 : 32'd4);
            case (r_state)
                S_REQ: begin
                    if (w_issue) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (memValid) begin
                        r_skipHalf <= 1'b0;
                        r_fetchPC  <= r_fetchPC + 32'd4;
                        r_state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (memValid) r_state <= S_REQ;
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: a halfword-level reference stream model feeds an
// expectation queue that a separate monitor drains on every accepted instruction.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memValid;
    logic [31:0] memData;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        instValid;
    logic        instReady;
    logic [31:0] instruction;
    logic        compressed;
    logic [31:0] instPC;

    always #5 clk = ~clk;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .memReq(memReq), .memAddr(memAddr), .memValid(memValid), .memData(memData),
        .redirect(redirect), .redirectTarget(redirectTarget),
        .instValid(instValid), .instReady(instReady), .instruction(instruction),
        .compressed(compressed), .instPC(instPC)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    logic [31:0] refPC;
    logic [31:0] mem [0:255];
    int          vectors = 0;
    int          errors = 0;
    int          transfers = 0;
    int          memLat = 1;
    bit          memRandLat = 0;
    bit          injectStale = 0;

    int          reqAt, reqSeen, t0;
    bit          holdBad;
    logic [31:0] snapInst, snapPC;
    logic        snapC;

    // Reference view of memory: the halfword stored at any even byte address.
    function automatic logic [15:0] halfAt(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [15:0] randHalf();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            if (h[1:0] == 2'b11) h[1:0] = 2'b00;
        end else begin
            h[1:0] = 2'b11;
        end
        return h;
    endfunction

    // Walk the instruction stream from refPC: a 16-bit parcel unless its low bits are 11.
    task automatic refFill(input int n);
        exp_t e;
        logic [15:0] lo;
        for (int k = 0; k < n; k++) begin
            lo   = halfAt(refPC);
            e.pc = refPC;
            if (lo[1:0] != 2'b11) begin
                e.instr = {16'h0, lo};
                e.comp  = 1'b1;
                refPC   = refPC + 32'd2;
            end else begin
                e.instr = {halfAt(refPC + 32'd2), lo};
                e.comp  = 1'b0;
                refPC   = refPC + 32'd4;
            end
            expQ.push_back(e);
        end
    endtask

    task automatic restartModel(input logic [31:0] pc);
        expQ.delete();
        refPC = {pc[31:1], 1'b0};
        refFill(16);
    endtask

    task automatic pushConst(input logic [31:0] pc, input logic [31:0] instr, input logic comp);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.comp  = comp;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input bit anyAddr, input logic [31:0] addr, input int limit, input string name);
        bit found = 0;
        for (int c = 0; c < limit && !found; c++) begin
            @(negedge clk);
            if (memReq === 1'b1 && (anyAddr || memAddr == addr)) found = 1;
            else step(1);
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL %s: no memReq within %0d cycles", name, limit);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " instValid"}, 32'(instValid), 32'd0);
        checkOutput({tag, " instruction"}, instruction, 32'h0);
        checkOutput({tag, " compressed"}, 32'(compressed), 32'd0);
        checkOutput({tag, " instPC"}, instPC, 32'h0);
        checkOutput({tag, " memReq"}, 32'(memReq), 32'd1);
        checkOutput({tag, " memAddr"}, memAddr, 32'h0);
    endtask

    // One cycle of random traffic: backpressure, occasional redirects and resets.
    task automatic applyStimulus();
        int r;
        logic [31:0] target;
        instReady      = ($urandom_range(0, 3) != 0);
        redirectTarget = $urandom;
        r = $urandom_range(0, 99);
        if (r < 3) begin
            target = (r == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            redirect       = 1'b1;
            redirectTarget = target;
            step(1);
            redirect = 1'b0;
            restartModel(target);
        end else if (r == 3 && $urandom_range(0, 9) == 0) begin
            rst = 1'b0;
            step(1);
            rst = 1'b1;
            restartModel(32'h0);
        end else begin
            step(1);
        end
    endtask

    // Memory: single outstanding request, response after memLat cycles, reset with the DUT.
    initial begin : memoryModel
        bit          sReq, sRst, pending;
        logic [31:0] sAddr, pAddr;
        int          waitCnt;
        pending  = 0;
        waitCnt  = 0;
        pAddr    = 32'h0;
        memValid = 1'b0;
        memData  = 32'h0;
        forever begin
            @(posedge clk);
            sReq  = (memReq === 1'b1);
            sAddr = memAddr;
            sRst  = (rst === 1'b1);
            #1;
            memValid = 1'b0;
            memData  = $urandom;
            if (!sRst) begin
                pending = 0;
            end else if (sReq) begin
                checkOutput("memReq while outstanding", 32'(pending), 32'd0);
                checkOutput("memAddr alignment", 32'(sAddr[1:0]), 32'd0);
                pending = 1;
                pAddr   = sAddr;
                waitCnt = memRandLat ? $urandom_range(1, 4) : memLat;
            end
            if (pending) begin
                waitCnt--;
                if (waitCnt == 0) begin
                    memValid = 1'b1;
                    memData  = mem[pAddr[9:2]];
                    pending  = 0;
                end
            end
            if (injectStale) begin
                memValid    = 1'b1;
                memData     = 32'hFFFF_FFFF;
                injectStale = 0;
            end
        end
    end

    // Monitor: every accepted instruction must match the head of the expectation queue.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && instValid === 1'b1 && instReady === 1'b1) begin
                if (expQ.size() == 0) refFill(8);
                monE = expQ.pop_front();
                transfers++;
                vectors++;
                if (instPC !== monE.pc || instruction !== monE.instr || compressed !== monE.comp) begin
                    errors++;
                    $display("[TB] FAIL transfer: got pc=%h inst=%h c=%b, expected pc=%h inst=%h c=%b",
                             instPC, instruction, compressed, monE.pc, monE.instr, monE.comp);
                end
            end else if (rst === 1'b1 && instValid === 1'b0) begin
                checkOutput("idle instruction", instruction, 32'h0);
                checkOutput("idle compressed", 32'(compressed), 32'd0);
            end
        end
    end

    initial begin : driver
        rst            = 1'b0;
        redirect       = 1'b0;
        redirectTarget = 32'h0;
        instReady      = 1'b1;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0001_0001;
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h4505_4501;
        mem[2] = 32'h0093_4501;
        mem[3] = 32'h1234_00A0;
        mem[64] = 32'h4515_ABCD;

        // Basic stream and straddling 32-bit instruction from reset.
        memLat = 1;
        step(2);
        rst = 1'b1;
        expQ.delete();
        pushConst(32'h0, 32'h00A0_0093, 1'b0);
        pushConst(32'h4, 32'h0000_4501, 1'b1);
        pushConst(32'h6, 32'h0000_4505, 1'b1);
        pushConst(32'h8, 32'h0000_4501, 1'b1);
        pushConst(32'hA, 32'h00A0_0093, 1'b0);
        pushConst(32'hE, 32'h0000_1234, 1'b1);
        refPC = 32'h10;
        @(negedge clk);
        checkResetOutputs("reset");
        t0 = transfers;
        step(40);
        checkOutput("stream progress", 32'(transfers - t0 >= 6), 32'd1);

        // Redirect to a halfword-aligned target with the 0x10 request outstanding.
        memLat = 3;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        restartModel(32'h0);
        waitReq(1'b0, 32'h10, 100, "req 0x10");
        step(1);
        redirect       = 1'b1;
        redirectTarget = 32'h0000_0102;
        @(negedge clk);
        checkOutput("no req in redirect cycle", 32'(memReq), 32'd0);
        step(1);
        redirect = 1'b0;
        expQ.delete();
        pushConst(32'h102, 32'h0000_4515, 1'b1);
        refPC = 32'h104;
        refFill(16);
        reqAt = -1;
        for (int c = 0; c < 10 && reqAt < 0; c++) begin
            @(negedge clk);
            if (memReq === 1'b1) begin
                reqAt = c;
                checkOutput("post-redirect addr", memAddr, 32'h100);
            end
            step(1);
        end
        checkOutput("post-redirect req cycle", 32'(reqAt), 32'd2);
        step(30);

        // Backpressure on distinct compressed parcels.
        for (int k = 0; k < 256; k++) mem[k] = {16'(k * 8 + 5), 16'(k * 8 + 1)};
        memLat = 1;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        restartModel(32'h0);
        step(6);
        instReady = 1'b0;
        reqSeen = 0;
        holdBad = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 5 && memReq === 1'b1) reqSeen++;
            if (c == 5) begin
                checkOutput("stall valid", 32'(instValid), 32'd1);
                snapInst = instruction;
                snapPC   = instPC;
                snapC    = compressed;
            end else if (c > 5) begin
                if (instruction !== snapInst || instPC !== snapPC || compressed !== snapC || instValid !== 1'b1)
                    holdBad = 1;
            end
            step(1);
        end
        checkOutput("stall no memReq", 32'(reqSeen), 32'd0);
        checkOutput("stall outputs hold", 32'(holdBad), 32'd0);
        instReady = 1'b1;
        step(30);

        // Redirect landing exactly on a response.
        memLat = 2;
        step(3);
        waitReq(1'b1, 32'h0, 20, "req before coincident redirect");
        step(2);
        redirect       = 1'b1;
        redirectTarget = 32'h40;
        @(negedge clk);
        checkOutput("coincident no req", 32'(memReq), 32'd0);
        step(1);
        redirect = 1'b0;
        restartModel(32'h40);
        @(negedge clk);
        checkOutput("coincident instValid", 32'(instValid), 32'd0);
        checkOutput("coincident memReq", 32'(memReq), 32'd1);
        checkOutput("coincident memAddr", memAddr, 32'h40);
        step(20);

        // Reset pulse while waiting, followed by a stale response.
        memLat = 3;
        step(2);
        waitReq(1'b1, 32'h0, 20, "req before reset");
        step(1);
        rst = 1'b0;
        injectStale = 1;
        @(negedge clk);
        checkOutput("reset cycle memReq", 32'(memReq), 32'd0);
        step(1);
        rst = 1'b1;
        restartModel(32'h0);
        @(negedge clk);
        checkResetOutputs("midreset");
        step(40);

        // Randomized traffic.
        for (int k = 0; k < 256; k++) mem[k] = {randHalf(), randHalf()};
        memRandLat = 1;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        restartModel(32'h0);
        t0 = transfers;
        for (int c = 0; c < 3000; c++) applyStimulus();
        checkOutput("random progress", 32'(transfers - t0 >= 500), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
